// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : mips_16 instruction-decode stage. Holds the IF/ID register and
//            the 8x16 register file, stalls fetch on RAW hazards against
//            EX/MEM, resolves BZ branches and drives the ID/EX register.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [15:0]         instruction,
  output logic                instruction_fetch_en,
  output logic                branch_taken,
  output logic [5:0]          branch_offset_imm,
  input  logic [2:0]          ex_dest,
  input  logic                ex_wen,
  input  logic [2:0]          mem_dest,
  input  logic                mem_wen,
  input  logic [2:0]          wb_dest,
  input  logic                wb_wen,
  input  logic [15:0]         wb_data,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [3:0]          idex_op,
  output logic [2:0]          idex_rd,
  output logic [15:0]         idex_a,
  output logic [15:0]         idex_b,
  output logic [15:0]         idex_st_data,
  output logic                idex_wen,
  output logic                idex_mem_rd,
  output logic                idex_mem_wr
);

  localparam logic [3:0] C_OP_NOP  = 4'd0;
  localparam logic [3:0] C_OP_SRU  = 4'd8;
  localparam logic [3:0] C_OP_LD   = 4'd10;
  localparam logic [3:0] C_OP_ST   = 4'd11;
  localparam logic [3:0] C_OP_BZ   = 4'd12;

  // Pipeline / register-file state
  logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [15:0]         ifid_instr_q, ifid_instr_d;
  logic [15:0]         rf_q [0:7];
  logic [15:0]         rf_d [0:7];
  logic [3:0]          op_q, op_d;
  logic [2:0]          rd_q, rd_d;
  logic [15:0]         a_q, a_d, b_q, b_d, st_q, st_d;
  logic                wen_q, wen_d, mrd_q, mrd_d, mwr_q, mwr_d;

  // Decode of the instruction sitting in IF/ID
  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [5:0]  imm6;
  logic        is_rtype, uses_rs, uses_rt, uses_rd, is_alu_mem;
  logic [15:0] rs_val, rt_val, rd_val;
  logic        stall;

  // Combinational read with write-through; r0 is hardwired to zero.
  function automatic logic [15:0] rf_read(input logic [2:0] a, input logic [15:0] stored,
                                          input logic we, input logic [2:0] wd,
                                          input logic [15:0] wdat);
    if (a == 3'd0)             return 16'd0;
    else if (we && (wd == a))  return wdat;
    else                       return stored;
  endfunction

  // A source register conflicts when an in-flight EX or MEM instruction will write it.
  function automatic logic reg_busy(input logic [2:0] s, input logic exw, input logic [2:0] exd,
                                    input logic mw, input logic [2:0] md);
    return (s != 3'd0) && ((exw && (s == exd)) || (mw && (s == md)));
  endfunction

  // Field decode, operand reads, hazard detection and branch resolution
  always_comb begin
    op         = ifid_instr_q[15:12];
    rd         = ifid_instr_q[11:9];
    rs         = ifid_instr_q[8:6];
    rt         = ifid_instr_q[5:3];
    imm6       = ifid_instr_q[5:0];
    is_rtype   = (op != C_OP_NOP) && (op <= C_OP_SRU);
    is_alu_mem = (op != C_OP_NOP) && (op <= C_OP_ST);
    uses_rs    = is_alu_mem;
    uses_rt    = is_rtype;
    uses_rd    = (op == C_OP_ST) || (op == C_OP_BZ);
    rs_val     = rf_read(rs, rf_q[rs], wb_wen, wb_dest, wb_data);
    rt_val     = rf_read(rt, rf_q[rt], wb_wen, wb_dest, wb_data);
    rd_val     = rf_read(rd, rf_q[rd], wb_wen, wb_dest, wb_data);
    stall      = (uses_rs && reg_busy(rs, ex_wen, ex_dest, mem_wen, mem_dest)) ||
                 (uses_rt && reg_busy(rt, ex_wen, ex_dest, mem_wen, mem_dest)) ||
                 (uses_rd && reg_busy(rd, ex_wen, ex_dest, mem_wen, mem_dest));
    instruction_fetch_en = !stall;
    branch_taken         = (op == C_OP_BZ) && !stall && (rd_val == 16'd0);
    branch_offset_imm    = imm6;
  end

  // Next-state for IF/ID, ID/EX and the register file
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (!stall) begin
      ifid_pc_d    = pc;
      ifid_instr_d = branch_taken ? 16'd0 : instruction;
    end

    // Default is a bubble; covers stalls, NOP, BZ and the unused opcodes.
    op_d  = C_OP_NOP;
    rd_d  = 3'd0;
    a_d   = 16'd0;
    b_d   = 16'd0;
    st_d  = 16'd0;
    wen_d = 1'b0;
    mrd_d = 1'b0;
    mwr_d = 1'b0;
    if (!stall && is_alu_mem) begin
      op_d  = op;
      rd_d  = rd;
      a_d   = rs_val;
      b_d   = is_rtype ? rt_val : {{10{imm6[5]}}, imm6};
      st_d  = (op == C_OP_ST) ? rd_val : 16'd0;
      wen_d = (op != C_OP_ST) && (rd != 3'd0);
      mrd_d = (op == C_OP_LD);
      mwr_d = (op == C_OP_ST);
    end

    for (int i = 0; i < 8; i++) begin
      rf_d[i] = rf_q[i];
      if ((i != 0) && wb_wen && (wb_dest == 3'(i))) rf_d[i] = wb_data;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= 16'd0;
      op_q         <= C_OP_NOP;
      rd_q         <= 3'd0;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      st_q         <= 16'd0;
      wen_q        <= 1'b0;
      mrd_q        <= 1'b0;
      mwr_q        <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'd0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      st_q         <= st_d;
      wen_q        <= wen_d;
      mrd_q        <= mrd_d;
      mwr_q        <= mwr_d;
      for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign id_pc        = ifid_pc_q;
  assign idex_op      = op_q;
  assign idex_rd      = rd_q;
  assign idex_a       = a_q;
  assign idex_b       = b_q;
  assign idex_st_data = st_q;
  assign idex_wen     = wen_q;
  assign idex_mem_rd  = mrd_q;
  assign idex_mem_wr  = mwr_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Self-checking bench for id_stage: directed scenarios followed by
//            random instruction/hazard/write-back traffic against a
//            behavioural pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pc;
  logic [15:0]   instruction;
  logic          instruction_fetch_en, branch_taken;
  logic [5:0]    branch_offset_imm;
  logic [2:0]    ex_dest, mem_dest, wb_dest;
  logic          ex_wen, mem_wen, wb_wen;
  logic [15:0]   wb_data;
  logic [PW-1:0] id_pc;
  logic [3:0]    idex_op;
  logic [2:0]    idex_rd;
  logic [15:0]   idex_a, idex_b, idex_st_data;
  logic          idex_wen, idex_mem_rd, idex_mem_wr;

  id_stage #(.PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .instruction_fetch_en(instruction_fetch_en), .branch_taken(branch_taken),
    .branch_offset_imm(branch_offset_imm),
    .ex_dest(ex_dest), .ex_wen(ex_wen), .mem_dest(mem_dest), .mem_wen(mem_wen),
    .wb_dest(wb_dest), .wb_wen(wb_wen), .wb_data(wb_data),
    .id_pc(id_pc), .idex_op(idex_op), .idex_rd(idex_rd), .idex_a(idex_a),
    .idex_b(idex_b), .idex_st_data(idex_st_data), .idex_wen(idex_wen),
    .idex_mem_rd(idex_mem_rd), .idex_mem_wr(idex_mem_wr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0]   m_regs [8];
  logic [PW-1:0] m_ifpc;
  logic [15:0]   m_ifin;
  logic [3:0]    e_op;
  logic [2:0]    e_rd;
  logic [15:0]   e_a, e_b, e_st;
  logic          e_wen, e_mrd, e_mwr;

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 16'd0;
    m_ifpc = '0; m_ifin = 16'd0;
    e_op = 0; e_rd = 0; e_a = 0; e_b = 0; e_st = 0; e_wen = 0; e_mrd = 0; e_mwr = 0;
  endtask

  // Set of registers (bit per register) an instruction reads; r0 never matters.
  function automatic logic [7:0] sources(input logic [15:0] ins);
    int o = int'(ins[15:12]);
    logic [7:0] m = 8'd0;
    if (o >= 1 && o <= 11) m[ins[8:6]]  = 1'b1;
    if (o >= 1 && o <= 8)  m[ins[5:3]]  = 1'b1;
    if (o == 11 || o == 12) m[ins[11:9]] = 1'b1;
    return m & 8'hFE;
  endfunction

  function automatic logic [15:0] rdv(input logic [2:0] r);
    if (r == 0) return 16'd0;
    if (wb_wen && wb_dest == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic check_idex();
    check("id_pc",    32'(id_pc), 32'(m_ifpc));
    check("idex_op",  32'(idex_op), 32'(e_op));
    check("idex_rd",  32'(idex_rd), 32'(e_rd));
    check("idex_a",   32'(idex_a), 32'(e_a));
    check("idex_b",   32'(idex_b), 32'(e_b));
    check("idex_st",  32'(idex_st_data), 32'(e_st));
    check("idex_wen", 32'(idex_wen), 32'(e_wen));
    check("idex_mrd", 32'(idex_mem_rd), 32'(e_mrd));
    check("idex_mwr", 32'(idex_mem_wr), 32'(e_mwr));
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic step(input logic [PW-1:0] p, input logic [15:0] ins,
                      input logic exw, input logic [2:0] exd,
                      input logic mw, input logic [2:0] md,
                      input logic ww, input logic [2:0] wd, input logic [15:0] wdat);
    int o;
    logic [7:0] busy;
    logic st, tk;
    logic [15:0] imm;
    pc = p; instruction = ins; ex_wen = exw; ex_dest = exd; mem_wen = mw; mem_dest = md;
    wb_wen = ww; wb_dest = wd; wb_data = wdat;
    #1;
    o = int'(m_ifin[15:12]);
    busy = 8'd0;
    if (exw) busy[exd] = 1'b1;
    if (mw)  busy[md]  = 1'b1;
    st = (sources(m_ifin) & busy) != 8'd0;
    tk = (o == 12) && !st && (rdv(m_ifin[11:9]) == 16'd0);
    check("fetch_en", 32'(instruction_fetch_en), 32'(!st));
    check("br_taken", 32'(branch_taken), 32'(tk));
    check("br_off",   32'(branch_offset_imm), 32'(m_ifin[5:0]));
    imm = 16'(signed'(m_ifin[5:0]));
    e_op = 0; e_rd = 0; e_a = 0; e_b = 0; e_st = 0; e_wen = 0; e_mrd = 0; e_mwr = 0;
    if (!st && o >= 1 && o <= 11) begin
      e_op  = m_ifin[15:12];
      e_rd  = m_ifin[11:9];
      e_a   = rdv(m_ifin[8:6]);
      e_b   = (o <= 8) ? rdv(m_ifin[5:3]) : imm;
      e_st  = (o == 11) ? rdv(m_ifin[11:9]) : 16'd0;
      e_wen = (o <= 10) && (m_ifin[11:9] != 0);
      e_mrd = (o == 10);
      e_mwr = (o == 11);
    end
    if (!st) begin
      m_ifpc = p;
      m_ifin = tk ? 16'd0 : ins;
    end
    if (ww && wd != 0) m_regs[wd] = wdat;
    @(posedge clk); #1;
    check_idex();
  endtask

  task automatic plain(input logic [PW-1:0] p, input logic [15:0] ins);
    step(p, ins, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_idex();
    check("rst_fetch_en", 32'(instruction_fetch_en), 32'd1);
    check("rst_br_taken", 32'(branch_taken), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; pc = '0; instruction = 16'd0;
    ex_wen = 0; ex_dest = 0; mem_wen = 0; mem_dest = 0; wb_wen = 0; wb_dest = 0; wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idex();
    check("reset_fetch_en", 32'(instruction_fetch_en), 32'd1);
    check("reset_br_taken", 32'(branch_taken), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ADDI r1,r0,5 issues two edges later; r1 is written back meanwhile.
    plain(8'd1, 16'h9205);
    step(8'd2, 16'h0000, 0, 0, 0, 0, 1, 3'd1, 16'd5);
    check("addi_op",  32'(idex_op), 32'd9);
    check("addi_rd",  32'(idex_rd), 32'd1);
    check("addi_a",   32'(idex_a), 32'd0);
    check("addi_b",   32'(idex_b), 32'd5);
    check("addi_wen", 32'(idex_wen), 32'd1);

    // ADD r2,r1,r1 stalled by EX then MEM, then issues.
    plain(8'd3, 16'h1448);
    step(8'd4, 16'h0000, 1, 3'd1, 0, 0, 0, 0, 0);
    check("stall_ex_bubble", 32'(idex_wen), 32'd0);
    step(8'd4, 16'h0000, 0, 0, 1, 3'd1, 0, 0, 0);
    check("stall_mem_fetch_en", 32'(instruction_fetch_en), 32'd0);
    plain(8'd4, 16'h0000);
    check("add_op", 32'(idex_op), 32'd1);
    check("add_a",  32'(idex_a), 32'd5);
    check("add_b",  32'(idex_b), 32'd5);

    // Write-through: ADD r5,r3,r3 read while r3 is written.
    plain(8'd5, 16'h1AD8);
    step(8'd6, 16'h0000, 0, 0, 0, 0, 1, 3'd3, 16'h1234);
    check("wthru_a", 32'(idex_a), 32'h1234);

    // BZ r4,-3 with r4==0: taken, then wrong-path ADDI squashed.
    plain(8'd7, 16'hC83D);
    check("bz_taken",  32'(branch_taken), 32'd1);
    check("bz_offset", 32'(branch_offset_imm), 32'h3D);
    plain(8'd8, 16'h9FFF);
    check("bz_one_cycle", 32'(branch_taken), 32'd0);
    check("bz_pc_kept",   32'(id_pc), 32'd8);
    step(8'd9, 16'h0000, 0, 0, 0, 0, 1, 3'd4, 16'd7);
    check("squash_op",  32'(idex_op), 32'd0);
    check("squash_wen", 32'(idex_wen), 32'd0);

    // BZ r4 with r4==7: not taken.
    plain(8'd10, 16'hC83D);
    check("bz_not_taken", 32'(branch_taken), 32'd0);
    plain(8'd11, 16'h0000);

    // BZ r4 held by EX hazard; r4 cleared during the stall, then taken.
    step(8'd12, 16'hC83D, 1, 3'd4, 0, 0, 0, 0, 0);
    check("bz_stall_taken",    32'(branch_taken), 32'd0);
    check("bz_stall_fetch_en", 32'(instruction_fetch_en), 32'd0);
    step(8'd13, 16'h0000, 1, 3'd4, 0, 0, 1, 3'd4, 16'd0);
    ex_wen = 1'b0; wb_wen = 1'b0;
    #1;
    check("bz_release_taken", 32'(branch_taken), 32'd1);
    plain(8'd14, 16'h9FFF);
    plain(8'd15, 16'h9009);
    plain(8'd16, 16'h1200);
    check("addi_r0_op",  32'(idex_op), 32'd9);
    check("addi_r0_wen", 32'(idex_wen), 32'd0);
    plain(8'd17, 16'h0000);
    check("r0_reads_0", 32'(idex_a), 32'd0);

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      step(PW'($urandom), ins,
           ($urandom_range(0, 3) == 0), 3'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom),
           ($urandom_range(0, 1) == 0), 3'($urandom),
           ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
      if (i == 200) begin
        async_reset();
        // Every register must read back as zero after reset.
        for (int r = 1; r < 8; r++) begin
          plain(PW'(r), {4'd11, 3'(r), 3'(r), 6'd1});
          check("post_rst_a",  32'(idex_a), 32'd0);
          check("post_rst_st", 32'(idex_st_data), 32'd0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
